// File: rtl/ddr_arb_corefifo_gray_ptr_sync_if.sv
// Bus bundle for the Gray pointer synchroniser: source-side Gray pointers in and
// synchronised/decoded pointers, change strobes and status out.
interface ddr_arb_corefifo_gray_ptr_sync_if #(
   parameter int ADDRWIDTH = 3,
   parameter int NUM_CH    = 1
);
   localparam int PW = ADDRWIDTH + 1;

   logic                 sync_clr;
   logic [NUM_CH*PW-1:0] inp;
   logic [NUM_CH*PW-1:0] sync_out;
   logic [NUM_CH*PW-1:0] bin_out;
   logic [NUM_CH-1:0]    chg;
   logic                 sync_vld;
   logic [NUM_CH-1:0]    err;

   modport master (
      output sync_clr, inp,
      input  sync_out, bin_out, chg, sync_vld, err
   );

   modport slave (
      input  sync_clr, inp,
      output sync_out, bin_out, chg, sync_vld, err
   );
endinterface

// File: rtl/ddr_arb_corefifo_gray_ptr_sync.sv
// Multi-channel Gray pointer synchroniser, latency NUM_STAGES (Gray) / NUM_STAGES+1 (binary), no backpressure.
// Optional per-channel Gray-protocol checker built when GRAY_PTR_SYNC_ERR_CHK_EN is defined.
module ddr_arb_corefifo_gray_ptr_sync #(
   parameter int NUM_STAGES = 2,
   parameter int ADDRWIDTH  = 3,
   parameter int NUM_CH     = 1
) (
   input  logic                              clk,
   input  logic                              rstn,
   ddr_arb_corefifo_gray_ptr_sync_if.slave   bus
);
   localparam int PW = ADDRWIDTH + 1;
   localparam int CW = $clog2(NUM_STAGES + 2);
   localparam logic [CW-1:0] VLD_CNT = CW'(NUM_STAGES + 1);

   logic [CW-1:0]        warm_cnt;
   logic                 vld;
   logic [NUM_CH*PW-1:0] sync_all;
   logic [NUM_CH*PW-1:0] bin_all;
   logic [NUM_CH-1:0]    chg_all;
   logic [NUM_CH-1:0]    err_all;

   // Warm-up counter saturates once the chain and decode register hold fresh data.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         warm_cnt <= '0;
      end else if (bus.sync_clr) begin
         warm_cnt <= '0;
      end else if (warm_cnt != VLD_CNT) begin
         warm_cnt <= warm_cnt + 1'b1;
      end
   end

   assign vld = (warm_cnt == VLD_CNT);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [PW-1:0] stage [NUM_STAGES];
      logic [PW-1:0] gray;
      logic [PW-1:0] bin_nxt;
      logic [PW-1:0] bin_q;
      logic          chg_q;

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            for (int i = 0; i < NUM_STAGES; i++) stage[i] <= '0;
         end else if (bus.sync_clr) begin
            for (int i = 0; i < NUM_STAGES; i++) stage[i] <= '0;
         end else begin
            stage[0] <= bus.inp[k*PW +: PW];
            for (int i = 1; i < NUM_STAGES; i++) stage[i] <= stage[i-1];
         end
      end

      assign gray = stage[NUM_STAGES-1];

      // Each binary bit is the XOR of all Gray bits at and above it.
      always_comb begin
         bin_nxt = '0;
         for (int j = 0; j < PW; j++) bin_nxt[j] = ^(gray >> j);
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            bin_q <= '0;
            chg_q <= 1'b0;
         end else if (bus.sync_clr) begin
            bin_q <= '0;
            chg_q <= 1'b0;
         end else begin
            bin_q <= bin_nxt;
            chg_q <= vld && (bin_nxt != bin_q);
         end
      end

      assign sync_all[k*PW +: PW] = gray;
      assign bin_all[k*PW +: PW]  = bin_q;
      assign chg_all[k]           = chg_q;

`ifdef GRAY_PTR_SYNC_ERR_CHK_EN
      logic [PW-1:0] prev_q;
      logic          err_q;

      // A legal Gray stream never moves more than one bit between samples.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            prev_q <= '0;
            err_q  <= 1'b0;
         end else if (bus.sync_clr) begin
            prev_q <= '0;
            err_q  <= 1'b0;
         end else begin
            prev_q <= gray;
            if (vld && ($countones(gray ^ prev_q) > 1)) err_q <= 1'b1;
         end
      end

      assign err_all[k] = err_q;
`else
      assign err_all[k] = 1'b0;
`endif
   end

   assign bus.sync_out = sync_all;
   assign bus.bin_out  = bin_all;
   assign bus.chg      = chg_all;
   assign bus.err      = err_all;
   assign bus.sync_vld = vld;
endmodule

// File: tb/tb_ddr_arb_corefifo_gray_ptr_sync.sv
// Directed bench for the Gray pointer synchroniser (NUM_STAGES=2, ADDRWIDTH=3, NUM_CH=2).
module tb_ddr_arb_corefifo_gray_ptr_sync;
   logic clk;
   logic rstn;
   int   n_chk;
   int   n_err;

`ifdef GRAY_PTR_SYNC_ERR_CHK_EN
   localparam logic [1:0] VIOL_ERR = 2'b01;
`else
   localparam logic [1:0] VIOL_ERR = 2'b00;
`endif

   ddr_arb_corefifo_gray_ptr_sync_if #(.ADDRWIDTH(3), .NUM_CH(2)) bus ();

   ddr_arb_corefifo_gray_ptr_sync #(
      .NUM_STAGES (2),
      .ADDRWIDTH  (3),
      .NUM_CH     (2)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] so, input logic [7:0] bo,
                            input logic [1:0] c, input logic v, input logic [1:0] e);
      check_val({tag, ".sync_out"}, 32'(bus.sync_out), 32'(so));
      check_val({tag, ".bin_out"},  32'(bus.bin_out),  32'(bo));
      check_val({tag, ".chg"},      32'(bus.chg),      32'(c));
      check_val({tag, ".sync_vld"}, 32'(bus.sync_vld), 32'(v));
      check_val({tag, ".err"},      32'(bus.err),      32'(e));
   endtask

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk        = 0;
      n_err        = 0;
      rstn         = 1'b0;
      bus.inp      = 8'hFF;
      bus.sync_clr = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_all("reset", 8'h00, 8'h00, 2'b00, 1'b0, 2'b00);

      // Warm-up after reset with inp held at FF (Gray 1111 -> bin 1010 per channel)
      rstn = 1'b1;
      tick();
      check_val("warm.e1.vld", 32'(bus.sync_vld), 32'd0);
      tick();
      check_all("warm.e2", 8'hFF, 8'h00, 2'b00, 1'b0, 2'b00);
      tick();
      check_all("warm.e3", 8'hFF, 8'hAA, 2'b00, 1'b1, 2'b00);

      // Clear to a zero baseline
      bus.inp      = 8'h00;
      bus.sync_clr = 1'b1;
      tick();
      check_all("clr0", 8'h00, 8'h00, 2'b00, 1'b0, 2'b00);
      bus.sync_clr = 1'b0;
      tick();
      tick();
      check_val("clr0.e2.vld", 32'(bus.sync_vld), 32'd0);
      tick();
      check_all("clr0.e3", 8'h00, 8'h00, 2'b00, 1'b1, 2'b00);

      // Latency: ch0 0000 -> 0110
      bus.inp = 8'h06;
      tick();
      check_all("lat.e0", 8'h00, 8'h00, 2'b00, 1'b1, 2'b00);
      tick();
      check_all("lat.e1", 8'h06, 8'h00, 2'b00, 1'b1, 2'b00);
      tick();
      check_all("lat.e2", 8'h06, 8'h04, 2'b01, 1'b1, 2'b00);
      tick();
      check_all("lat.e3", 8'h06, 8'h04, 2'b00, 1'b1, 2'b00);

      // Channels: ch1 held at Gray 0101 (bin 0110), ch0 steps 0 -> 1 -> 3
      bus.inp      = 8'h50;
      bus.sync_clr = 1'b1;
      tick();
      bus.sync_clr = 1'b0;
      repeat (3) tick();
      check_all("ch.base", 8'h50, 8'h60, 2'b00, 1'b1, 2'b00);
      bus.inp = 8'h51;
      tick();
      check_val("ch.s1.e0.chg", 32'(bus.chg), 32'd0);
      tick();
      check_val("ch.s1.e1.chg", 32'(bus.chg), 32'd0);
      tick();
      check_all("ch.s1.e2", 8'h51, 8'h61, 2'b01, 1'b1, 2'b00);
      bus.inp = 8'h53;
      tick();
      check_val("ch.s2.e0.chg", 32'(bus.chg), 32'd0);
      tick();
      tick();
      check_all("ch.s2.e2", 8'h53, 8'h62, 2'b01, 1'b1, 2'b00);
      tick();
      check_all("ch.s2.e3", 8'h53, 8'h62, 2'b00, 1'b1, 2'b00);

      // Wrap: ch0 Gray 1000 (bin 1111) -> 0000
      bus.inp      = 8'h08;
      bus.sync_clr = 1'b1;
      tick();
      bus.sync_clr = 1'b0;
      repeat (3) tick();
      check_all("wrap.base", 8'h08, 8'h0F, 2'b00, 1'b1, 2'b00);
      bus.inp = 8'h00;
      tick();
      tick();
      check_all("wrap.e1", 8'h00, 8'h0F, 2'b00, 1'b1, 2'b00);
      tick();
      check_all("wrap.e2", 8'h00, 8'h00, 2'b01, 1'b1, 2'b00);
      tick();
      check_all("wrap.e3", 8'h00, 8'h00, 2'b00, 1'b1, 2'b00);

      // Violation: ch0 0000 -> 0011 (two bits at once)
      bus.inp = 8'h03;
      tick();
      tick();
      check_all("viol.e1", 8'h03, 8'h00, 2'b00, 1'b1, 2'b00);
      tick();
      check_all("viol.e2", 8'h03, 8'h02, 2'b01, 1'b1, VIOL_ERR);
      repeat (2) tick();
      check_all("viol.hold", 8'h03, 8'h02, 2'b00, 1'b1, VIOL_ERR);
      bus.sync_clr = 1'b1;
      tick();
      check_all("viol.clr", 8'h00, 8'h00, 2'b00, 1'b0, 2'b00);
      bus.sync_clr = 1'b0;
      repeat (3) tick();
      check_all("viol.rewarm", 8'h03, 8'h02, 2'b00, 1'b1, 2'b00);

      // Clear while ch0 0011 -> 0010 is in flight
      bus.inp = 8'h02;
      tick();
      bus.sync_clr = 1'b1;
      tick();
      check_all("mid.clr", 8'h00, 8'h00, 2'b00, 1'b0, 2'b00);
      bus.sync_clr = 1'b0;
      tick();
      check_all("mid.e1", 8'h00, 8'h00, 2'b00, 1'b0, 2'b00);
      tick();
      check_all("mid.e2", 8'h02, 8'h00, 2'b00, 1'b0, 2'b00);
      tick();
      check_all("mid.e3", 8'h02, 8'h03, 2'b00, 1'b1, 2'b00);
      tick();
      check_all("mid.e4", 8'h02, 8'h03, 2'b00, 1'b1, 2'b00);

      // Asynchronous reset mid-cycle
      #2 rstn = 1'b0;
      #1;
      check_all("arst", 8'h00, 8'h00, 2'b00, 1'b0, 2'b00);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
